// File: rtl/mem_access_unit.sv
// Memory-stage data-memory access: lane alignment, req/ack handshake, load extension.
// Define MEM_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES with a BUS_ERR_M pulse.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        MEM_W_En_M,
    input  logic [2:0]  MEM_Control_M,
    input  logic [1:0]  Result_Src_Sel_M,
    input  logic [31:0] ALU_Out_M,
    input  logic [31:0] SrcB_Reg_M,
    output logic        DMEM_Req,
    output logic        DMEM_W_En,
    output logic [31:0] DMEM_Addr,
    output logic [3:0]  DMEM_Byte_En,
    output logic [31:0] DMEM_W_Data,
    input  logic        DMEM_Ack,
    input  logic [31:0] DMEM_R_Data,
    output logic [31:0] RD_Data_M,
    output logic        STALL_M,
    output logic        MISALIGN_M,
    output logic        BUS_ERR_M
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state;
    logic [31:0] cap;
    logic        bus_err;

    logic        is_load, access, is_b, is_h, is_w, uns, misalign;
    logic        go, in_wait;
    logic [3:0]  byte_en;
    logic [31:0] shifted, ext, rd_word, w_data;

    generate
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 2");
        end
    endgenerate

    assign access   = MEM_W_En_M | (Result_Src_Sel_M == 2'b01);
    assign is_load  = ~MEM_W_En_M & (Result_Src_Sel_M == 2'b01);
    // 011 and 11x fall through to word size
    assign is_b     = (MEM_Control_M[1:0] == 2'b00);
    assign is_h     = (MEM_Control_M[1:0] == 2'b01);
    assign is_w     = ~is_b & ~is_h;
    assign uns      = MEM_Control_M[2];
    assign misalign = (is_h & ALU_Out_M[0]) | (is_w & |ALU_Out_M[1:0]);

    always_comb begin
        byte_en = 4'b1111;
        w_data  = SrcB_Reg_M;
        ext     = shifted;
        unique case (1'b1)
            is_b: begin
                byte_en = 4'b0001 << ALU_Out_M[1:0];
                w_data  = {4{SrcB_Reg_M[7:0]}};
                ext     = {{24{shifted[7] & ~uns}}, shifted[7:0]};
            end
            is_h: begin
                byte_en = 4'b0011 << {ALU_Out_M[1], 1'b0};
                w_data  = {2{SrcB_Reg_M[15:0]}};
                ext     = {{16{shifted[15] & ~uns}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

    assign shifted = DMEM_R_Data >> {ALU_Out_M[1:0], 3'b000};
    assign rd_word = is_load ? ext : 32'd0;

    // Gating with RST_N makes the request vanish the moment reset asserts
    assign go      = RST_N & (state == IDLE) & access & ~misalign;
    assign in_wait = RST_N & (state == WAIT);

    assign DMEM_Req     = go | in_wait;
    assign DMEM_W_En    = DMEM_Req & MEM_W_En_M;
    assign DMEM_Addr    = {ALU_Out_M[31:2], 2'b00};
    assign DMEM_Byte_En = DMEM_Req ? byte_en : 4'b0000;
    assign DMEM_W_Data  = w_data;
    assign STALL_M      = (go & ~DMEM_Ack) | in_wait;
    assign MISALIGN_M   = RST_N & (state == IDLE) & access & misalign;
    assign BUS_ERR_M    = bus_err;

    always_comb begin
        RD_Data_M = 32'd0;
        if (go & DMEM_Ack)
            RD_Data_M = rd_word;
        else if (RST_N & (state == DONE))
            RD_Data_M = cap;
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            cap     <= 32'd0;
            bus_err <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt     <= '0;
`endif
        end else begin
            bus_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (go & ~DMEM_Ack)
                        state <= WAIT;
                end
                WAIT: begin
                    if (DMEM_Ack) begin
                        cap   <= rd_word;
                        state <= DONE;
`ifdef MEM_TIMEOUT_EN
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        cap     <= 32'd0;
                        bus_err <= 1'b1;
                        state   <= DONE;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed checks for mem_access_unit: stores, loads, stalls, misalign, reset, timeout.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        MEM_W_En_M;
    logic [2:0]  MEM_Control_M;
    logic [1:0]  Result_Src_Sel_M;
    logic [31:0] ALU_Out_M;
    logic [31:0] SrcB_Reg_M;
    logic        DMEM_Req;
    logic        DMEM_W_En;
    logic [31:0] DMEM_Addr;
    logic [3:0]  DMEM_Byte_En;
    logic [31:0] DMEM_W_Data;
    logic        DMEM_Ack;
    logic [31:0] DMEM_R_Data;
    logic [31:0] RD_Data_M;
    logic        STALL_M;
    logic        MISALIGN_M;
    logic        BUS_ERR_M;

    int checks = 0;
    int errors = 0;
    int req_cycles;
    int stall_cycles;

    always #5 CLK = ~CLK;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .MEM_W_En_M       (MEM_W_En_M),
        .MEM_Control_M    (MEM_Control_M),
        .Result_Src_Sel_M (Result_Src_Sel_M),
        .ALU_Out_M        (ALU_Out_M),
        .SrcB_Reg_M       (SrcB_Reg_M),
        .DMEM_Req         (DMEM_Req),
        .DMEM_W_En        (DMEM_W_En),
        .DMEM_Addr        (DMEM_Addr),
        .DMEM_Byte_En     (DMEM_Byte_En),
        .DMEM_W_Data      (DMEM_W_Data),
        .DMEM_Ack         (DMEM_Ack),
        .DMEM_R_Data      (DMEM_R_Data),
        .RD_Data_M        (RD_Data_M),
        .STALL_M          (STALL_M),
        .MISALIGN_M       (MISALIGN_M),
        .BUS_ERR_M        (BUS_ERR_M)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        MEM_W_En_M       = 1'b0;
        MEM_Control_M    = 3'b000;
        Result_Src_Sel_M = 2'b00;
        ALU_Out_M        = 32'd0;
        SrcB_Reg_M       = 32'd0;
        DMEM_Ack         = 1'b0;
        DMEM_R_Data      = 32'd0;
    endtask

    task automatic op(input logic st, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] b);
        MEM_W_En_M       = st;
        MEM_Control_M    = f3;
        Result_Src_Sel_M = st ? 2'b00 : 2'b01;
        ALU_Out_M        = addr;
        SrcB_Reg_M       = b;
    endtask

    initial begin
        RST_N = 1'b0;
        idle_in();
        #3;
        chk("rst_req", 32'(DMEM_Req), 32'd0);
        chk("rst_stall", 32'(STALL_M), 32'd0);
        chk("rst_rd", RD_Data_M, 32'd0);
        chk("rst_mis", 32'(MISALIGN_M), 32'd0);
        chk("rst_berr", 32'(BUS_ERR_M), 32'd0);
        chk("rst_be", 32'(DMEM_Byte_En), 32'd0);
        nxt();
        nxt();
        RST_N = 1'b1;
        #2;
        chk("idle_req", 32'(DMEM_Req), 32'd0);

        // SB zero-wait
        nxt();
        op(1'b1, 3'b000, 32'h1002, 32'h0000_00A5);
        DMEM_Ack = 1'b1;
        #1;
        chk("sb_req", 32'(DMEM_Req), 32'd1);
        chk("sb_wen", 32'(DMEM_W_En), 32'd1);
        chk("sb_be", 32'(DMEM_Byte_En), 32'h4);
        chk("sb_wd", DMEM_W_Data, 32'hA5A5_A5A5);
        chk("sb_addr", DMEM_Addr, 32'h1000);
        chk("sb_stall", 32'(STALL_M), 32'd0);
        nxt();
        idle_in();
        #1;
        chk("sb_after_req", 32'(DMEM_Req), 32'd0);
        chk("sb_after_stall", 32'(STALL_M), 32'd0);

        // LB, ack two cycles after the request
        nxt();
        op(1'b0, 3'b000, 32'h2003, 32'd0);
        DMEM_R_Data = 32'h80FF_FFFF;
        req_cycles = 0;
        stall_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            DMEM_Ack = (i == 2);
            #1;
            if (DMEM_Req) req_cycles++;
            if (STALL_M) stall_cycles++;
            chk("lb_be", 32'(DMEM_Byte_En), 32'h8);
            nxt();
        end
        DMEM_Ack = 1'b0;
        DMEM_R_Data = 32'hFFFF_FFFF;
        #1;
        chk("lb_stall_cycles", 32'(stall_cycles), 32'd3);
        chk("lb_req_cycles", 32'(req_cycles), 32'd3);
        chk("lb_done_rd", RD_Data_M, 32'hFFFF_FF80);
        chk("lb_done_req", 32'(DMEM_Req), 32'd0);
        chk("lb_done_stall", 32'(STALL_M), 32'd0);
        nxt();
        idle_in();
        #1;
        chk("lb_after_rd", RD_Data_M, 32'd0);

        // LHU / LH zero-wait
        op(1'b0, 3'b101, 32'h2002, 32'd0);
        DMEM_Ack = 1'b1;
        DMEM_R_Data = 32'hBEEF_1234;
        #1;
        chk("lhu_rd", RD_Data_M, 32'h0000_BEEF);
        chk("lhu_be", 32'(DMEM_Byte_En), 32'hC);
        chk("lhu_stall", 32'(STALL_M), 32'd0);
        nxt();
        MEM_Control_M = 3'b001;
        #1;
        chk("lh_rd", RD_Data_M, 32'hFFFF_BEEF);

        // LBU at offset 1
        nxt();
        op(1'b0, 3'b100, 32'h0000_0101, 32'd0);
        DMEM_R_Data = 32'h0000_9A00;
        #1;
        chk("lbu_rd", RD_Data_M, 32'h0000_009A);
        chk("lbu_be", 32'(DMEM_Byte_En), 32'h2);

        // unused encoding 011 acts as word
        nxt();
        op(1'b0, 3'b011, 32'h0000_0040, 32'd0);
        DMEM_R_Data = 32'h8765_4321;
        #1;
        chk("f011_rd", RD_Data_M, 32'h8765_4321);
        chk("f011_be", 32'(DMEM_Byte_En), 32'hF);

        // SH at offset 2
        nxt();
        op(1'b1, 3'b001, 32'h0000_0502, 32'h1234_ABCD);
        #1;
        chk("sh_be", 32'(DMEM_Byte_En), 32'hC);
        chk("sh_wd", DMEM_W_Data, 32'hABCD_ABCD);
        chk("sh_rd", RD_Data_M, 32'd0);

        // misaligned LW and SH
        nxt();
        idle_in();
        op(1'b0, 3'b010, 32'h3001, 32'd0);
        #1;
        chk("lw_mis_req", 32'(DMEM_Req), 32'd0);
        chk("lw_mis_flag", 32'(MISALIGN_M), 32'd1);
        chk("lw_mis_stall", 32'(STALL_M), 32'd0);
        chk("lw_mis_rd", RD_Data_M, 32'd0);
        nxt();
        op(1'b1, 3'b001, 32'h3001, 32'hFFFF_FFFF);
        #1;
        chk("sh_mis_flag", 32'(MISALIGN_M), 32'd1);
        chk("sh_mis_req", 32'(DMEM_Req), 32'd0);
        nxt();
        idle_in();
        #1;
        chk("mis_clear", 32'(MISALIGN_M), 32'd0);

        // stray ack with no request
        DMEM_Ack = 1'b1;
        DMEM_R_Data = 32'h1111_1111;
        #1;
        chk("stray_req", 32'(DMEM_Req), 32'd0);
        chk("stray_rd", RD_Data_M, 32'd0);
        nxt();
        DMEM_Ack = 1'b0;
        #1;
        chk("stray_stall", 32'(STALL_M), 32'd0);

        // reset asserted while in WAIT
        op(1'b1, 3'b010, 32'h4000, 32'h0BAD_F00D);
        nxt();
        #1;
        chk("wait_req", 32'(DMEM_Req), 32'd1);
        chk("wait_stall", 32'(STALL_M), 32'd1);
        RST_N = 1'b0;
        #1;
        chk("rstw_req", 32'(DMEM_Req), 32'd0);
        chk("rstw_stall", 32'(STALL_M), 32'd0);
        nxt();
        RST_N = 1'b1;
        op(1'b1, 3'b010, 32'h4000, 32'hDEAD_BEEF);
        DMEM_Ack = 1'b1;
        #1;
        chk("sw_req", 32'(DMEM_Req), 32'd1);
        chk("sw_be", 32'(DMEM_Byte_En), 32'hF);
        chk("sw_wd", DMEM_W_Data, 32'hDEAD_BEEF);
        chk("sw_stall", 32'(STALL_M), 32'd0);
        nxt();
        idle_in();

`ifdef MEM_TIMEOUT_EN
        // no ack: four WAIT cycles, then DONE with a bus error
        op(1'b0, 3'b010, 32'h5000, 32'd0);
        #1;
        chk("to_idle_req", 32'(DMEM_Req), 32'd1);
        nxt();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_wait_req", 32'(DMEM_Req), 32'd1);
            chk("to_wait_berr", 32'(BUS_ERR_M), 32'd0);
            nxt();
        end
        #1;
        chk("to_done_req", 32'(DMEM_Req), 32'd0);
        chk("to_done_stall", 32'(STALL_M), 32'd0);
        chk("to_done_berr", 32'(BUS_ERR_M), 32'd1);
        chk("to_done_rd", RD_Data_M, 32'd0);
        nxt();
        idle_in();
        #1;
        chk("to_berr_clear", 32'(BUS_ERR_M), 32'd0);
`else
        // without the timeout, a long wait just keeps stalling
        op(1'b0, 3'b010, 32'h5000, 32'd0);
        for (int i = 0; i < 20; i++) nxt();
        #1;
        chk("long_req", 32'(DMEM_Req), 32'd1);
        chk("long_stall", 32'(STALL_M), 32'd1);
        chk("long_berr", 32'(BUS_ERR_M), 32'd0);
        DMEM_Ack = 1'b1;
        DMEM_R_Data = 32'hCAFE_0001;
        nxt();
        DMEM_Ack = 1'b0;
        #1;
        chk("long_done_rd", RD_Data_M, 32'hCAFE_0001);
        nxt();
        idle_in();
`endif

        nxt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data-memory interface between the execute-to-memory pipeline register and the memory-to-writeback register. It aligns stores into byte lanes, drives a request/acknowledge handshake to data memory, and extracts and sign- or zero-extends load data. While a handshake is outstanding it stalls the pipeline, and it flags misaligned accesses and optional bus timeouts.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in WAIT before a bus error is raised (≥2). Used only with MEM_TIMEOUT_EN.

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- MEM_W_En_M  in  1  store enable
- MEM_Control_M  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
- Result_Src_Sel_M  in  2  value 01 marks a load
- ALU_Out_M  in  32  effective byte address
- SrcB_Reg_M  in  32  store data
- DMEM_Req  out  1  memory request
- DMEM_W_En  out  1  request is a write
- DMEM_Addr  out  32  word address {ALU_Out_M[31:2],2'b00}
- DMEM_Byte_En  out  4  active byte lanes
- DMEM_W_Data  out  32  lane-replicated store data
- DMEM_Ack  in  1  memory completes the request this cycle
- DMEM_R_Data  in  32  read word, valid with DMEM_Ack
- RD_Data_M  out  32  extended load result
- STALL_M  out  1  freeze the PC, IF/ID, ID/EX and EX/MEM registers
- MISALIGN_M  out  1  misaligned-access flag
- BUS_ERR_M  out  1  timeout flag

## Operation
- An access is a store when MEM_W_En_M=1, or a load when Result_Src_Sel_M=01. A store takes priority if both are set.
- Misaligned cases:
  - H or HU with addr[0]=1.
  - W with addr[1:0]≠0.
  - Effect: no request is issued, MISALIGN_M=1 combinationally, STALL_M=0, and RD_Data_M=0.
- Byte enables are the same for loads and stores:
  - B/BU: 4'b0001<<addr[1:0].
  - H/HU: 4'b0011<<{addr[1],1'b0}.
  - W: 4'b1111.
- Store data: B gives {4{SrcB[7:0]}}, H gives {2{SrcB[15:0]}}, W gives SrcB.
- Load extraction: shift the word right by addr[1:0]×8, take 8 or 16 or 32 bits, then sign-extend (B, H) or zero-extend (BU, HU).
- FSM states: IDLE, WAIT, DONE.
  - IDLE, aligned access: DMEM_Req=1 combinationally.
    - DMEM_Ack=1 in the same cycle: zero-wait completion, STALL_M=0, RD_Data_M taken from DMEM_R_Data, stay in IDLE.
    - Otherwise: STALL_M=1, go to WAIT.
  - WAIT: hold DMEM_Req=1 and STALL_M=1.
    - On DMEM_Ack: capture the extracted load data into a register and go to DONE. STALL_M stays 1 in that cycle.
  - DONE: DMEM_Req=0, STALL_M=0, RD_Data_M taken from the capture register.
    - Return to IDLE unconditionally. DONE never re-issues a request for the held instruction.
- Non-access cycles: DMEM_Req=0, STALL_M=0, RD_Data_M=0.
- Unused encodings (011, 11x): treated as W.

## Timing
- Reset values:
  - State IDLE, wait counter 0, capture register 0.
  - With inputs idle, all outputs are 0.
  - DMEM_Req drops immediately on RST_N assertion, including mid-WAIT.
- Latency:
  - Zero-wait access costs 0 stall cycles.
  - Ack N≥1 cycles after the request costs N+1 stall cycles (WAIT cycles, plus the Ack cycle, then DONE).
- DMEM_Addr, DMEM_Byte_En, DMEM_W_Data and DMEM_W_En are stable throughout WAIT. The upstream pipeline register is frozen by STALL_M, so the inputs are held.
- DMEM_Ack while DMEM_Req=0 is ignored.
- MISALIGN_M and BUS_ERR_M are single-cycle pulses per instruction.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter runs in WAIT and clears on leaving WAIT.
  - If it reaches TIMEOUT_CYCLES without DMEM_Ack, drop DMEM_Req, capture 0, pulse BUS_ERR_M for one cycle, and go to DONE.
  - A DMEM_Ack on the final count cycle wins over the timeout.
- MEM_TIMEOUT_EN undefined:
  - No counter; WAIT lasts until DMEM_Ack.
  - BUS_ERR_M is tied to 0.

## Test plan
- SB with addr=0x1002 and SrcB=0x000000A5, zero-wait ack → Byte_En=0100, W_Data=0xA5A5A5A5, Addr=0x1000, STALL_M never 1.
- LB with addr=0x2003, R_Data=0x80FFFFFF, Ack after 2 cycles → STALL_M high for 3 cycles, then RD_Data_M=0xFFFFFF80 in DONE, and Req issued exactly once.
- LHU with addr=0x2002, R_Data=0xBEEF1234, zero-wait → RD_Data_M=0x0000BEEF. LH with the same inputs → 0xFFFFBEEF.
- LW with addr=0x3001 → no Req, MISALIGN_M=1 for one cycle, STALL_M=0.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no Ack → Req drops after 4 WAIT cycles, BUS_ERR_M pulses, RD_Data_M=0, back to IDLE.
- RST_N asserted in WAIT → DMEM_Req=0 and STALL_M=0 immediately. After release, a new SW to 0x4000 issues Byte_En=1111.
